// File: rtl/key_debounce_pkg.sv
// Shared types and sizing helpers for the push-button debouncer.
package key_pkg;

  typedef enum logic [1:0] {
    REL  = 2'd0,
    PDB  = 2'd1,
    HELD = 2'd2,
    RDB  = 2'd3
  } key_state_e;

  // Counter width able to hold the largest of the three cycle counts.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_debounce_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous board input.
module sync_2ff #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next-state for the synchroniser chain
  always_comb begin
    meta_d = i_d;
    sync_d = meta_q;
  end

  // Synchroniser flops, loaded with the idle level in reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/key_debounce.sv
// Debounces one raw push-button into a level plus press/release/auto-repeat pulses.
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat,
  output logic o_pulse
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t DB_LAST  = cnt_t'(DEBOUNCE_CYCLES - 1);
  localparam cnt_t RD_LAST  = cnt_t'(REPEAT_DELAY - 1);
  localparam cnt_t RP_LAST  = cnt_t'(REPEAT_PERIOD - 1);
  localparam cnt_t CNT_MAX  = {CW{1'b1}};
  localparam cnt_t CNT_ZERO = {CW{1'b0}};
  localparam cnt_t CNT_ONE  = cnt_t'(1);

  function automatic cnt_t sat_inc(input cnt_t v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  logic       key_sync_s;
  logic       pr_s;
  key_state_e state_q, state_d;
  cnt_t       db_cnt_q, db_cnt_d;
  cnt_t       hold_cnt_q, hold_cnt_d;
  logic       rep_phase_q, rep_phase_d;
  logic       press_s, release_s, repeat_s;
  logic       level_q, level_d;
  logic       press_q, press_d;
  logic       release_q, release_d;
  logic       repeat_q, repeat_d;
  logic       pulse_q, pulse_d;

  sync_2ff #(
    .RESET_VAL (KEY_ACTIVE_LOW)
  ) u_sync_key (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_key),
    .o_q     (key_sync_s)
  );

  assign pr_s = key_sync_s ^ KEY_ACTIVE_LOW;

  // Debounce FSM; rep_phase selects first-delay versus steady repeat period
  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    rep_phase_d = rep_phase_q;
    press_s     = 1'b0;
    release_s   = 1'b0;
    repeat_s    = 1'b0;
    case (state_q)
      REL: begin
        if (pr_s) begin
          state_d  = PDB;
          db_cnt_d = CNT_ZERO;
        end else begin
          state_d = REL;
        end
      end
      PDB: begin
        if (!pr_s) begin
          state_d = REL;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = HELD;
          press_s     = 1'b1;
          hold_cnt_d  = CNT_ZERO;
          rep_phase_d = 1'b0;
        end else begin
          db_cnt_d = sat_inc(db_cnt_q);
        end
      end
      HELD: begin
        if (!pr_s) begin
          state_d  = RDB;
          db_cnt_d = CNT_ZERO;
        end else if (REPEAT_EN &&
                     ((!rep_phase_q && (hold_cnt_q == RD_LAST)) ||
                      ( rep_phase_q && (hold_cnt_q == RP_LAST)))) begin
          repeat_s    = 1'b1;
          hold_cnt_d  = CNT_ZERO;
          rep_phase_d = 1'b1;
        end else begin
          hold_cnt_d = sat_inc(hold_cnt_q);
        end
      end
      RDB: begin
        if (pr_s) begin
          state_d = HELD;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = REL;
          release_s = 1'b1;
        end else begin
          db_cnt_d = sat_inc(db_cnt_q);
        end
      end
      default: begin
        state_d = REL;
      end
    endcase
  end

  // Output register inputs
  always_comb begin
    level_d   = (state_d == HELD) || (state_d == RDB);
    press_d   = press_s;
    release_d = release_s;
    repeat_d  = repeat_s;
    pulse_d   = press_s | repeat_s;
  end

  // State, counters and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= REL;
      db_cnt_q    <= CNT_ZERO;
      hold_cnt_q  <= CNT_ZERO;
      rep_phase_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      repeat_q    <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      rep_phase_q <= rep_phase_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      repeat_q    <= repeat_d;
      pulse_q     <= pulse_d;
    end
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_repeat  = repeat_q;
  assign o_pulse   = pulse_q;

endmodule

// File: tb/tb_key_debounce.sv
// Randomised and directed bench for key_debounce against a run-length reference model.
module tb_key_debounce;

  localparam int DB  = 8;
  localparam int RD  = 40;
  localparam int RP  = 10;
  localparam bit ACT_LOW = 1'b1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key = 1'b1;
  logic o_level, o_press, o_release, o_repeat, o_pulse;

  int n_checks = 0;
  int n_fail = 0;
  int step_no = 0;
  int n_press = 0, n_release = 0, n_repeat = 0;
  int press_at = -1, release_at = -1, first_rep_at = -1;

  // Reference model: pr history, accepted level, mismatch run length, held ticks
  logic m_h1, m_h2, m_level;
  int   m_run, m_ticks;
  logic e_press, e_release, e_repeat, e_pulse;

  key_debounce #(
    .DEBOUNCE_CYCLES (DB),
    .KEY_ACTIVE_LOW  (ACT_LOW),
    .REPEAT_EN       (1'b1),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_key     (key),
    .o_level   (o_level),
    .o_press   (o_press),
    .o_release (o_release),
    .o_repeat  (o_repeat),
    .o_pulse   (o_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s at step %0d: got %0d, expected %0d", tag, step_no, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_h1 = 1'b1; m_h2 = 1'b1; m_level = 1'b0;
    m_run = 0; m_ticks = 0;
    e_press = 1'b0; e_release = 1'b0; e_repeat = 1'b0; e_pulse = 1'b0;
  endtask

  // Accept a new level after DB+1 consecutive differing samples; repeat at tick RD, RD+RP, ...
  task automatic model_edge(input logic key_v);
    logic pr;
    pr = m_h2 ^ ACT_LOW;
    m_h2 = m_h1;
    m_h1 = key_v;
    e_press = 1'b0; e_release = 1'b0; e_repeat = 1'b0;
    if (pr != m_level) begin
      m_run++;
      if (m_run == DB + 1) begin
        m_run = 0;
        if (m_level) e_release = 1'b1;
        else begin
          e_press = 1'b1;
          m_ticks = 0;
        end
        m_level = ~m_level;
      end
    end else begin
      if (m_level && m_run == 0) begin
        m_ticks++;
        if (m_ticks == RD || (m_ticks > RD && ((m_ticks - RD) % RP) == 0)) e_repeat = 1'b1;
      end
      m_run = 0;
    end
    e_pulse = e_press | e_repeat;
  endtask

  task automatic check_outputs();
    chk("level",   o_level,   m_level);
    chk("press",   o_press,   e_press);
    chk("release", o_release, e_release);
    chk("repeat",  o_repeat,  e_repeat);
    chk("pulse",   o_pulse,   e_pulse);
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge
  task automatic step(input logic key_v);
    key = key_v;
    @(posedge clk);
    model_edge(key_v);
    @(negedge clk);
    step_no++;
    check_outputs();
    if (o_press)   begin n_press++;   press_at = step_no;   end
    if (o_release) begin n_release++; release_at = step_no; end
    if (o_repeat)  begin
      n_repeat++;
      if (first_rep_at < 0) first_rep_at = step_no;
    end
  endtask

  task automatic steps(input logic key_v, input int n);
    for (int i = 0; i < n; i++) step(key_v);
  endtask

  task automatic clear_counts();
    n_press = 0; n_release = 0; n_repeat = 0;
    press_at = -1; release_at = -1; first_rep_at = -1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check_outputs();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    int t0;
    logic lvl;
    int len;
    model_reset();
    @(negedge clk);
    do_reset(3);

    // 1: idle key, no pulses
    clear_counts();
    steps(1'b1, 100);
    chk("idle_press_cnt", n_press, 0);
    chk("idle_level", o_level, 0);

    // 2: clean press and release latency
    clear_counts();
    t0 = step_no;
    steps(1'b0, 20);
    chk("clean_press_cnt", n_press, 1);
    chk("clean_press_lat", press_at - t0, 11);
    chk("clean_level_hi", o_level, 1);
    t0 = step_no;
    steps(1'b1, 20);
    chk("clean_rel_cnt", n_release, 1);
    chk("clean_rel_lat", release_at - t0, 11);
    chk("clean_level_lo", o_level, 0);

    // 3: 3-cycle bounces then stable press
    clear_counts();
    for (int i = 0; i < 30; i++) step(((i / 3) % 2) != 0);
    chk("bounce_no_press", n_press, 0);
    t0 = step_no;
    steps(1'b0, 15);
    chk("bounce_press_cnt", n_press, 1);
    chk("bounce_press_lat", press_at - t0, 11);

    // 4: short high glitch while held
    clear_counts();
    steps(1'b1, 5);
    steps(1'b0, 10);
    chk("glitch_no_rel", n_release, 0);
    chk("glitch_no_press", n_press, 0);
    chk("glitch_level", o_level, 1);
    steps(1'b1, 20);

    // 5: auto-repeat while held
    clear_counts();
    t0 = step_no;
    steps(1'b0, 11);
    chk("rep_press_lat", press_at - t0, 11);
    steps(1'b0, 100);
    chk("rep_first_off", first_rep_at - press_at, RD);
    chk("rep_count", n_repeat, 7);
    steps(1'b1, 30);
    chk("rep_stop", n_repeat, 7);
    chk("rep_rel_cnt", n_release, 1);

    // 6: reset while held, key stays pressed
    clear_counts();
    steps(1'b0, 25);
    do_reset(3);
    t0 = step_no;
    steps(1'b0, 15);
    chk("rst_press_lat", press_at - t0, 11);
    chk("rst_no_rel", n_release, 0);
    steps(1'b1, 20);

    // 7: random runs of varying length around the debounce threshold
    lvl = 1'b1;
    for (int r = 0; r < 300; r++) begin
      lvl = ~lvl;
      len = $urandom_range(1, (r % 5 == 0) ? 60 : 14);
      steps(lvl, len);
    end
    steps(1'b1, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
